multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select, including the 2-bit alu_op consumed by the ALU-control decoder (LW/SW=00, BEQ=01, R-type=10).
- Sits between the instruction register opcode field and the datapath; handshakes with memory via mem_ready.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
clk  input  1  rising-edge clock, sole clock
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], stable from DECODE until instruction end
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  memory address mux, 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  writeback mux, 1=MDR
reg_dst  output  1  dest reg mux, 1=rd, 0=rt
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  output  2  to ALU-control decoder
pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse on unknown opcode
retire  output  1  one-cycle pulse in final state of each instruction
state  output  4  current state encoding, for debug

Behaviour:
- Moore FSM: outputs decode from state only, except the mem_ready-qualified enables noted below. Any output not listed for a state is 0.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
- Reset:
  - Any cycle with rst=1 forces all outputs to 0, including state output bits.
  - State becomes FETCH at that edge.
  - Reset mid-instruction abandons the instruction: no write or retire pulse.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, no retire.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW→MEMRD, SW→MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next state FETCH.
- MEMWR: mem_write=1, i_or_d=1 for every cycle until mem_ready=1. retire=mem_ready. Then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, retire=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next state FETCH.
- Latency with mem_ready held 1, FETCH to retire inclusive:
  - LW 5 cycles; SW, R-type, ADDI 4 cycles; BEQ, J 3 cycles.
  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Unused encodings 12-15: all outputs 0, next state FETCH.
- mem_read and mem_write are never both 1.
- reg_write, pc_write and pc_write_cond are never 1 in the same cycle.

Test Plan:
1. rst=1 for 2 cycles mid-EXEC, then released → all outputs 0 during reset. state=0 and mem_read=1 on the first cycle after release. No reg_write or retire observed.
2. opcode=000000, mem_ready=1 → state sequence 0,1,6,7,0. alu_op=10 in EXEC. reg_write=1 and reg_dst=1 only in ALUWB. retire pulses once on cycle 4.
3. opcode=100011, mem_ready low 3 cycles in FETCH and 2 in MEMRD → FETCH holds 4 cycles with ir_write=0 until the ready cycle. MEMRD holds 3 cycles. MEMWB has mem_to_reg=1. Total 10 cycles.
4. opcode=101011 → sequence 0,1,2,5,0. mem_write=1 and i_or_d=1 in MEMWR. reg_write never asserted.
5. opcode=000100, then 000010 → BEQ: pc_write_cond=1, alu_op=01, pc_source=01. J: pc_write=1, pc_source=10. Each takes 3 cycles.
6. opcode=111111 → illegal_op=1 for one cycle in DECODE, return to FETCH, no retire. Then opcode=001000 → sequence 0,1,10,11,0 with alu_src_b=10 in ADDIEX.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control : main control FSM of the multi-cycle MIPS datapath   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_ADDIEX = 4'd10;
    localparam logic [3:0] c_ADDIWB = 4'd11;

    logic [3:0] r_state;
    logic [3:0] w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) w_next = c_MEMADR;
                else if (opcode == OP_RTYPE)            w_next = c_EXEC;
                else if (opcode == OP_BEQ)              w_next = c_BRANCH;
                else if (opcode == OP_J)                w_next = c_JUMP;
                else if (opcode == OP_ADDI)             w_next = c_ADDIEX;
                else                                    w_next = c_FETCH;
            end
            c_MEMADR: begin
                if (opcode == OP_LW)      w_next = c_MEMRD;
                else if (opcode == OP_SW) w_next = c_MEMWR;
                else                      w_next = c_FETCH;
            end
            c_MEMRD:  w_next = mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWR:  w_next = mem_ready ? c_FETCH : c_MEMWR;
            c_EXEC:   w_next = c_ALUWB;
            c_ADDIEX: w_next = c_ADDIWB;
            default:  w_next = c_FETCH;
        endcase
    end

    // Reset masks every output combinationally, including the debug state.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        retire        = 1'b0;
        state         = 4'd0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                c_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                c_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !(opcode == OP_RTYPE || opcode == OP_LW ||
                                   opcode == OP_SW    || opcode == OP_BEQ ||
                                   opcode == OP_J     || opcode == OP_ADDI);
                end
                c_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                c_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                c_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                c_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end
                c_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                c_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                c_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    retire        = 1'b1;
                end
                c_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                end
                c_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                c_ADDIWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
